present_player_seq: RTL and testbench

Parametrised, handshaked PRESENT permutation layer (pLayer) for the cipher datapath. Accepts one WIDTH-bit state word, applies the PRESENT bit permutation (forward or inverse) LANES bits per cycle, then holds the result until the downstream stage accepts it. It sits between the S-box layer and round-key addition in the round pipeline, and generalises the fixed 64-bit, 1-bit-per-cycle permutation with configurable width, throughput and a decrypt mode.

---
 rtl/present_player_seq_pkg.sv | 59 +++++
 rtl/present_player_seq_if.sv | 51 +++++
 rtl/present_player_seq_lane_mux.sv | 47 ++++
 rtl/present_player_seq.sv | 147 ++++++++++++++
 tb/tb_present_player_seq.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/present_player_seq_pkg.sv
// -----------------------------------------------------------------------------
// present_pkg
// Shared definitions for the PRESENT permutation layer (pLayer) block.
//
// Contents:
//   state_e               - sequencer states (IDLE, BUSY, DONE)
//   player_index          - P(i): destination of input bit i in the forward pLayer
//   player_inv_index      - source bit of output bit i in the inverse pLayer
//   player_fwd_src_index  - source bit of output bit j in the forward pLayer
//   idx_width             - width of a lane counter able to count n lanes
// -----------------------------------------------------------------------------
package present_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   // P(i) = (Q*i) mod (WIDTH-1) with Q = WIDTH/4, and the top bit maps to itself.
   // The product is formed in 64 bits, which is always at least twice the index
   // width for any realistic WIDTH, so Q*i can never wrap before the modulo.
   function automatic int unsigned player_index(input int unsigned i,
                                                input int unsigned width);
      logic [63:0] prod;
      if (i == width - 1) begin
         return width - 1;
      end
      prod = 64'(width / 4) * 64'(i);
      return 32'(prod % 64'(width - 1));
   endfunction

   // The inverse layer is written as out[i] = in[P(i)], so its gather source is
   // P itself.
   function automatic int unsigned player_inv_index(input int unsigned i,
                                                    input int unsigned width);
      return player_index(i, width);
   endfunction

   // The forward layer scatters in[i] to out[P(i)]. Since 4*Q = WIDTH is 1 modulo
   // WIDTH-1, the inverse of P is multiplication by 4, which turns the scatter
   // into the gather out[j] = in[(4*j) mod (WIDTH-1)].
   function automatic int unsigned player_fwd_src_index(input int unsigned j,
                                                        input int unsigned width);
      logic [63:0] prod;
      if (j == width - 1) begin
         return width - 1;
      end
      prod = 64'd4 * 64'(j);
      return 32'(prod % 64'(width - 1));
   endfunction

   // A single-lane configuration still needs a one-bit counter to keep the
   // vector widths legal.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/present_player_seq_if.sv
// -----------------------------------------------------------------------------
// present_player_seq_if
// Handshake bundle between the S-box stage, the pLayer sequencer and the
// round-key stage.
//
// Signals:
//   in_valid   - in_data / in_inverse are valid
//   in_ready   - sequencer can accept a word this cycle
//   in_data    - state word to permute
//   in_inverse - 0 = forward (encrypt), 1 = inverse (decrypt)
//   out_valid  - out_data holds a complete permuted word
//   out_ready  - downstream accepts out_data
//   out_data   - permuted word
//
// Modports:
//   master - the side that supplies words and consumes results
//   slave  - the pLayer sequencer
// -----------------------------------------------------------------------------
interface present_player_seq_if #(
   parameter int unsigned WIDTH = 64
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_inverse;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport master (
      output in_valid,
      output in_data,
      output in_inverse,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  in_inverse,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data
   );

endinterface

// File: rtl/present_player_seq_lane_mux.sv
// -----------------------------------------------------------------------------
// player_lane_mux
// Combinational gather for one group of LANES output bits of the pLayer.
//
// Ports:
//   word_i     - latched input state word
//   laneIdx_i  - which group of LANES output bits to produce
//   inverse_i  - 0 = forward pLayer, 1 = inverse pLayer
//   lane_o     - output bits laneIdx_i*LANES .. laneIdx_i*LANES+LANES-1
// -----------------------------------------------------------------------------
module player_lane_mux
   import present_pkg::*;
#(
   parameter  int unsigned WIDTH = 64,
   parameter  int unsigned LANES = 1,
   localparam int unsigned N     = WIDTH / LANES,
   localparam int unsigned IW    = idx_width(N)
) (
   input  logic [WIDTH-1:0] word_i,
   input  logic [IW-1:0]    laneIdx_i,
   input  logic             inverse_i,
   output logic [LANES-1:0] lane_o
);

   logic [WIDTH-1:0] fwdWord;
   logic [WIDTH-1:0] invWord;
   logic [WIDTH-1:0] permWord;
   logic [WIDTH-1:0] shiftedWord;

   // Both permutations are fixed wiring: every output bit picks one input bit
   // chosen at elaboration, so no logic is spent on the index arithmetic.
   for (genvar j = 0; j < WIDTH; j++) begin : gGather
      localparam int unsigned FwdSrc = player_fwd_src_index(j, WIDTH);
      localparam int unsigned InvSrc = player_inv_index(j, WIDTH);
      assign fwdWord[j] = word_i[FwdSrc];
      assign invWord[j] = word_i[InvSrc];
   end

   // The mode picks one of the two fully permuted words, and the lane index
   // then selects the LANES-bit slice being written into the result this cycle.
   always_comb begin
      permWord    = inverse_i ? invWord : fwdWord;
      shiftedWord = permWord >> (32'(laneIdx_i) * LANES);
      lane_o      = shiftedWord[LANES-1:0];
   end

endmodule

// File: rtl/present_player_seq.sv
// -----------------------------------------------------------------------------
// present_player_seq
// Handshaked PRESENT permutation layer. Accepts one WIDTH-bit word, builds the
// permuted result LANES bits per cycle, then holds it until downstream accepts.
//
// Parameters:
//   WIDTH - state width, multiple of 4 and at least 8
//   LANES - result bits produced per cycle, power of two dividing WIDTH
//
// Ports:
//   clk_i  - rising-edge clock
//   rst_ni - synchronous active-low reset
//   bus    - present_player_seq_if slave modport (input/output handshakes)
//   busy_o - a permutation is in progress
// -----------------------------------------------------------------------------
module present_player_seq
   import present_pkg::*;
#(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned LANES = 1
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   present_player_seq_if.slave       bus,
   output logic                      busy_o
);

   localparam int unsigned N  = WIDTH / LANES;
   localparam int unsigned IW = idx_width(N);

   // Reject configurations the permutation or the lane slicing cannot support.
   if (((WIDTH % 4) != 0) || (WIDTH < 8)) begin : gBadWidth
      $fatal(1, "present_player_seq: WIDTH must be a multiple of 4 and at least 8");
   end
   if ((LANES == 0) || ((LANES & (LANES - 1)) != 0) || ((WIDTH % LANES) != 0)) begin : gBadLanes
      $fatal(1, "present_player_seq: LANES must be a power of two dividing WIDTH");
   end

   state_e           state_q;
   state_e           state_d;
   logic [IW-1:0]    laneIdx_q;
   logic [WIDTH-1:0] word_q;
   logic             inverse_q;
   logic [WIDTH-1:0] result_q;
   logic [LANES-1:0] laneBits;
   logic             acceptIn;
   logic             lastLane;

   assign acceptIn = bus.in_ready & bus.in_valid;
   assign lastLane = (laneIdx_q == IW'(N - 1));

   player_lane_mux #(
      .WIDTH (WIDTH),
      .LANES (LANES)
   ) u_lane_mux (
      .word_i    (word_q),
      .laneIdx_i (laneIdx_q),
      .inverse_i (inverse_q),
      .lane_o    (laneBits)
   );

   // State register. Reset returns to IDLE and abandons any word in flight.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. From DONE, a result handshake coinciding with a new
   // input goes straight back to BUSY so back-to-back words lose no cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (lastLane) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = bus.in_valid ? BUSY : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output decode. Everything comes from the registered state except the
   // out_ready term of in_ready, which lets DONE accept the next word in the
   // same cycle its result is taken.
   always_comb begin
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      busy_o        = 1'b0;
      case (state_q)
         IDLE: begin
            bus.in_ready = 1'b1;
         end
         BUSY: begin
            busy_o = 1'b1;
         end
         DONE: begin
            bus.out_valid = 1'b1;
            bus.in_ready  = bus.out_ready;
         end
         default: begin
            bus.in_ready = 1'b0;
         end
      endcase
      bus.out_data = result_q;
   end

   // Datapath. The input word and mode are captured only on acceptance and
   // then left alone; the result register is touched only while BUSY, one
   // lane per cycle, so it keeps the last finished word once the FSM leaves.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         laneIdx_q <= '0;
         word_q    <= '0;
         inverse_q <= 1'b0;
         result_q  <= '0;
      end else begin
         if (acceptIn) begin
            word_q    <= bus.in_data;
            inverse_q <= bus.in_inverse;
            laneIdx_q <= '0;
         end else if (state_q == BUSY) begin
            laneIdx_q <= lastLane ? '0 : laneIdx_q + 1'b1;
            for (int k = 0; k < int'(N); k++) begin
               if (laneIdx_q == IW'(k)) begin
                  result_q[k*LANES +: LANES] <= laneBits;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_present_player_seq.sv
// -----------------------------------------------------------------------------
// tb_present_player_seq
// Drives five pLayer instances in parallel (64/1, 64/8, 64/4, 64/64, 16/2) and
// checks every instance each cycle against a bit-scatter model of the pLayer
// and a cycle-count model of the handshake, plus hand-computed results.
// -----------------------------------------------------------------------------
module tb_present_player_seq;

   logic clk;
   logic checkEn;
   int   checks;
   int   errors;

   logic [4:0]  rstN;
   logic [4:0]  inValid;
   logic [4:0]  inInverse;
   logic [4:0]  outReady;
   logic [63:0] inData [5];

   wire  [4:0]  inReady;
   wire  [4:0]  outValid;
   wire  [4:0]  busyO;
   wire  [63:0] outData [5];

   int wOf [5] = '{64, 64, 64, 64, 16};
   int nOf [5] = '{64, 8, 16, 1, 8};

   int          mPhase   [5];
   int          mCount   [5];
   logic [63:0] mResult  [5];
   logic [63:0] mPending [5];

   present_player_seq_if #(.WIDTH(64)) ifA ();
   present_player_seq_if #(.WIDTH(64)) ifB ();
   present_player_seq_if #(.WIDTH(64)) ifC ();
   present_player_seq_if #(.WIDTH(64)) ifD ();
   present_player_seq_if #(.WIDTH(16)) ifE ();

   present_player_seq #(.WIDTH(64), .LANES(1))  dutA (.clk_i(clk), .rst_ni(rstN[0]), .bus(ifA.slave), .busy_o(busyO[0]));
   present_player_seq #(.WIDTH(64), .LANES(8))  dutB (.clk_i(clk), .rst_ni(rstN[1]), .bus(ifB.slave), .busy_o(busyO[1]));
   present_player_seq #(.WIDTH(64), .LANES(4))  dutC (.clk_i(clk), .rst_ni(rstN[2]), .bus(ifC.slave), .busy_o(busyO[2]));
   present_player_seq #(.WIDTH(64), .LANES(64)) dutD (.clk_i(clk), .rst_ni(rstN[3]), .bus(ifD.slave), .busy_o(busyO[3]));
   present_player_seq #(.WIDTH(16), .LANES(2))  dutE (.clk_i(clk), .rst_ni(rstN[4]), .bus(ifE.slave), .busy_o(busyO[4]));

   assign ifA.in_valid = inValid[0];   assign ifA.in_data = inData[0];        assign ifA.in_inverse = inInverse[0];
   assign ifA.out_ready = outReady[0]; assign inReady[0] = ifA.in_ready;      assign outValid[0] = ifA.out_valid;
   assign outData[0] = ifA.out_data;
   assign ifB.in_valid = inValid[1];   assign ifB.in_data = inData[1];        assign ifB.in_inverse = inInverse[1];
   assign ifB.out_ready = outReady[1]; assign inReady[1] = ifB.in_ready;      assign outValid[1] = ifB.out_valid;
   assign outData[1] = ifB.out_data;
   assign ifC.in_valid = inValid[2];   assign ifC.in_data = inData[2];        assign ifC.in_inverse = inInverse[2];
   assign ifC.out_ready = outReady[2]; assign inReady[2] = ifC.in_ready;      assign outValid[2] = ifC.out_valid;
   assign outData[2] = ifC.out_data;
   assign ifD.in_valid = inValid[3];   assign ifD.in_data = inData[3];        assign ifD.in_inverse = inInverse[3];
   assign ifD.out_ready = outReady[3]; assign inReady[3] = ifD.in_ready;      assign outValid[3] = ifD.out_valid;
   assign outData[3] = ifD.out_data;
   assign ifE.in_valid = inValid[4];   assign ifE.in_data = inData[4][15:0];  assign ifE.in_inverse = inInverse[4];
   assign ifE.out_ready = outReady[4]; assign inReady[4] = ifE.in_ready;      assign outValid[4] = ifE.out_valid;
   assign outData[4] = {48'd0, ifE.out_data};

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case some handshake never completes.
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference pLayer written directly as the bit scatter out[P(i)] = in[i]
   // (forward) or out[i] = in[P(i)] (inverse).
   function automatic logic [63:0] permute(input logic [63:0] x, input int w, input logic inv);
      logic [63:0] r;
      int p;
      r = '0;
      for (int i = 0; i < w; i++) begin
         p = (i == w - 1) ? i : (i * (w / 4)) % (w - 1);
         if (!inv) r[p] = x[i];
         else      r[i] = x[p];
      end
      return r;
   endfunction

   task automatic chk(input int k, input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL dut%0d %s: got %h expected %h", k, name, act, exp);
      end
   endtask

   // Handshake model: an accepted word is finished after exactly N cycles,
   // then waits for out_ready; DONE can take a new word on the same edge.
   always @(posedge clk) begin
      for (int k = 0; k < 5; k++) begin
         if (!rstN[k]) begin
            mPhase[k]  <= 0;
            mCount[k]  <= 0;
            mResult[k] <= '0;
         end else begin
            case (mPhase[k])
               0: if (inValid[k]) begin
                     mPending[k] <= permute(inData[k], wOf[k], inInverse[k]);
                     mCount[k]   <= nOf[k];
                     mPhase[k]   <= 1;
                  end
               1: begin
                     mCount[k] <= mCount[k] - 1;
                     if (mCount[k] == 1) begin
                        mPhase[k]  <= 2;
                        mResult[k] <= mPending[k];
                     end
                  end
               default: if (outReady[k]) begin
                     if (inValid[k]) begin
                        mPending[k] <= permute(inData[k], wOf[k], inInverse[k]);
                        mCount[k]   <= nOf[k];
                        mPhase[k]   <= 1;
                     end else begin
                        mPhase[k] <= 0;
                     end
                  end
            endcase
         end
      end
   end

   // Per-cycle comparison of every instance against the model.
   always @(negedge clk) begin
      if (checkEn) begin
         for (int k = 0; k < 5; k++) begin
            chk(k, "in_ready", inReady[k], (mPhase[k] == 0) || (mPhase[k] == 2 && outReady[k]));
            chk(k, "out_valid", outValid[k], mPhase[k] == 2);
            chk(k, "busy", busyO[k], mPhase[k] == 1);
            if (mPhase[k] != 1) chk(k, "out_data", outData[k], mResult[k]);
         end
      end
   end

   task automatic applyStimulus(input int k, input logic [63:0] d, input logic inv);
      int guard;
      guard = 0;
      inValid[k]   = 1'b1;
      inData[k]    = d;
      inInverse[k] = inv;
      #1;
      while (!inReady[k] && guard < 1000) begin
         @(posedge clk); #2;
         guard++;
      end
      chk(k, "accept_ready", inReady[k], 1);
      @(posedge clk); #1;
      inValid[k] = 1'b0;
   endtask

   task automatic waitValid(input int k, output int lat);
      lat = 0;
      while (!outValid[k] && lat < 2000) begin
         @(posedge clk); #1;
         lat++;
      end
      chk(k, "valid_timeout", outValid[k], 1);
   endtask

   task automatic popWord(input int k, input int delay, output logic [63:0] d);
      repeat (delay) begin
         @(posedge clk); #1;
      end
      d = outData[k];
      outReady[k] = 1'b1;
      @(posedge clk); #1;
      outReady[k] = 1'b0;
   endtask

   task automatic checkOutput(input int k, input logic [63:0] d, input logic inv,
                              input logic [63:0] expData, input int expLat);
      int lat;
      logic [63:0] r;
      applyStimulus(k, d, inv);
      waitValid(k, lat);
      popWord(k, 0, r);
      chk(k, "latency", lat, expLat);
      chk(k, "result", r, expData);
   endtask

   task automatic roundTrip(input int k, input int count);
      logic [63:0] w, r, b;
      int lat;
      for (int n = 0; n < count; n++) begin
         w = {$urandom(), $urandom()};
         if (wOf[k] == 16) w = w & 64'hFFFF;
         applyStimulus(k, w, 1'b0);
         waitValid(k, lat);
         popWord(k, $urandom_range(0, 2), r);
         chk(k, "rt_fwd_latency", lat, nOf[k]);
         chk(k, "rt_fwd_data", r, permute(w, wOf[k], 1'b0));
         applyStimulus(k, r, 1'b1);
         waitValid(k, lat);
         popWord(k, $urandom_range(0, 2), b);
         chk(k, "rt_back", b, w);
      end
   endtask

   // Backpressure on the 64/1 instance: a 20-cycle stall, then a result
   // handshake and a new word on the same edge.
   task automatic backpressure();
      int lat;
      logic [63:0] r;
      applyStimulus(0, 64'h100, 1'b0);
      waitValid(0, lat);
      chk(0, "bp_latency", lat, 64);
      inValid[0] = 1'b1;
      inData[0]  = 64'h10;
      inInverse[0] = 1'b0;
      repeat (20) begin
         chk(0, "bp_data_stable", outData[0], 64'h4);
         chk(0, "bp_in_ready_low", inReady[0], 0);
         @(posedge clk); #1;
      end
      chk(0, "bp_still_valid", outValid[0], 1);
      outReady[0] = 1'b1;
      #1;
      chk(0, "bp_ready_comb", inReady[0], 1);
      @(posedge clk); #1;
      outReady[0] = 1'b0;
      inValid[0]  = 1'b0;
      chk(0, "bp_busy_next", busyO[0], 1);
      waitValid(0, lat);
      chk(0, "bp2_latency", lat, 64);
      popWord(0, 0, r);
      chk(0, "bp2_result", r, 64'h2);
   endtask

   // Reset the 64/1 instance once it is 30 lanes into a word.
   task automatic midReset();
      applyStimulus(0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      repeat (30) begin
         @(posedge clk); #1;
      end
      chk(0, "pre_reset_busy", busyO[0], 1);
      rstN[0] = 1'b0;
      @(posedge clk); #1;
      rstN[0] = 1'b1;
      chk(0, "rst_in_ready", inReady[0], 1);
      chk(0, "rst_out_valid", outValid[0], 0);
      chk(0, "rst_busy", busyO[0], 0);
      chk(0, "rst_out_data", outData[0], 64'h0);
      repeat (40) begin
         @(posedge clk); #1;
         chk(0, "rst_no_valid", outValid[0], 0);
      end
      checkOutput(0, 64'h10, 1'b0, 64'h2, 64);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      checkEn   = 1'b0;
      rstN      = '0;
      inValid   = '0;
      inInverse = '0;
      outReady  = '0;
      for (int k = 0; k < 5; k++) inData[k] = '0;
      @(posedge clk); #1;
      checkEn = 1'b1;
      @(posedge clk); #1;
      rstN = '1;
      for (int k = 0; k < 5; k++) begin
         chk(k, "reset_in_ready", inReady[k], 1);
         chk(k, "reset_out_valid", outValid[k], 0);
         chk(k, "reset_busy", busyO[k], 0);
         chk(k, "reset_out_data", outData[k], 64'h0);
      end
      $display("[TB] reset released, starting traffic");

      fork
         begin
            checkOutput(0, 64'h0000_0000_0000_0002, 1'b0, 64'h0000_0000_0001_0000, 64);
            checkOutput(0, 64'h0000_0000_0000_0010, 1'b0, 64'h0000_0000_0000_0002, 64);
            backpressure();
            midReset();
         end
         begin
            checkOutput(1, 64'h0000_0000_0001_0000, 1'b1, 64'h0000_0000_0000_0002, 8);
            checkOutput(1, 64'h8000_0000_0000_0001, 1'b1, 64'h8000_0000_0000_0001, 8);
            checkOutput(1, 64'h0000_0000_0000_0002, 1'b0, 64'h0000_0000_0001_0000, 8);
         end
         begin
            roundTrip(2, 1000);
         end
         begin
            checkOutput(3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
            checkOutput(3, 64'h0000_0000_0000_0000, 1'b0, 64'h0000_0000_0000_0000, 1);
            checkOutput(3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
            checkOutput(3, 64'h0000_0000_0000_0010, 1'b0, 64'h0000_0000_0000_0002, 1);
         end
         begin
            checkOutput(4, 64'h0000_0000_0000_0002, 1'b0, 64'h0000_0000_0000_0010, 8);
            roundTrip(4, 1000);
         end
      join

      @(posedge clk); #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
